shabal_msg_feeder: RTL and testbench
====================================

Name: shabal_msg_feeder

Overview:
Host-side sequencer placed directly in front of SHABAL_TOP. It accepts a byte-granular message as a stream of 32-bit words, applies Shabal padding (0x80 then zero fill to a 16-word block), and drives the init/load/fetch/idata/ack handshake in 16-bit halves. When the message is complete it fetches the 256-bit digest and returns it as eight 32-bit words on an output stream.

Parameters:
DIGEST_WORDS, 8, number of 32-bit digest words fetched (16 halfword fetches).
TIMEOUT_CYC, 1024, ack watchdog limit in clock cycles (used only with the optional feature).

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
s_valid  input  1  message word valid
s_ready  output  1  message word accepted when s_valid&s_ready
s_data  input  32  message word, little-endian: byte0 = [7:0]
s_last  input  1  final word of message
s_bytes  input  2  valid bytes in the final word; 0 means 4
m_valid  output  1  digest word valid
m_ready  input  1  digest consumer ready
m_data  output  32  digest word, word 0 first
m_last  output  1  marks digest word DIGEST_WORDS-1
init  output  1  to SHABAL_TOP init
load  output  1  to SHABAL_TOP load
fetch  output  1  to SHABAL_TOP fetch
idata  output  16  to SHABAL_TOP idata
ack  input  1  from SHABAL_TOP ack
odata  input  16  from SHABAL_TOP odata
err  output  1  sticky ack-timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset: the FSM goes to IDLE; all outputs are 0; the word counter (0..15), digest counter, pad flags and watchdog are cleared. Reset mid-operation aborts immediately with no drain.
- Request rule: each of init, load and fetch is held high (with idata stable for load) until ack is sampled high. The request then drops in the following cycle and stays low for at least 1 cycle (RTZ state) before the next request. At most one request is high at any time.
- States: IDLE -> INIT (on first s_valid) -> RTZ -> GET -> LOAD_HI -> RTZ -> LOAD_LO -> RTZ -> GET ... -> FETCH_HI -> RTZ -> FETCH_LO -> RTZ -> OUT -> FETCH_HI ... -> IDLE.
- GET: s_ready=1 for exactly the GET cycle(s) while data is sourced from the stream. The word is latched on the handshake. In pad and fill phases s_ready stays 0 and the word is generated internally.
- Load order: high halfword [31:16] first, then [15:0]. The word counter increments after LOAD_LO and wraps 15->0.
- Padding when the last word has n valid bytes (n=1..3): bytes n..3 are zeroed, and byte n is set to 0x80.
- Padding when the last word is full (s_bytes=0): an extra word 0x00000080 follows it.
- After the pad word, 0x00000000 words are loaded until the counter wraps to 0. If the pad word lands in word 15, no fill is added.
- After the wrap, the FSM goes to FETCH_HI.
- SHABAL_TOP withholds ack on fetch until the digest is ready. No separate busy poll is made.
- Fetch order: FETCH_HI captures odata into m_data[31:16], then FETCH_LO captures it into [15:0].
- OUT: m_valid=1 until m_ready. m_last=1 for digest word DIGEST_WORDS-1. After the last word the FSM returns to IDLE.
- Back-to-back messages: a new message is accepted only in IDLE, and each one starts with a fresh init.
- s_bytes is ignored when s_last=0.

Optional Feature:
SHABAL_FEED_TIMEOUT_EN
- Defined: a counter runs while any request is high and clears on ack. Reaching TIMEOUT_CYC sets err (sticky until rst), drops all requests and returns the FSM to IDLE.
- Undefined: there is no counter, err is tied 0, and the FSM waits for ack indefinitely.

Test Plan:
- Single word 0x00636261, s_bytes=3, s_last=1 -> 16 load pairs: word0 = hi 0x8063 / lo 0x6261, words1-15 = 0x0000. Then 16 fetches and 8 m_valid beats with m_last on beat 7.
- 16 full words, last full -> 16 data words, then a second block of 0x00000080 plus 15 zero words (32 load pairs total) before the first fetch.
- 15 full words, last full -> the pad word lands at word 15 and no fill is added: exactly 16 load pairs.
- Ack delayed 0/1/7 cycles per request -> requests held until ack, at least 1 low cycle between requests, idata stable while load is high.
- m_ready held low for 5 cycles on digest word 3 -> m_data/m_valid stable and no fetch issued until accepted.
- rst asserted during word 9 of a block, then a new message -> all outputs 0 immediately and a fresh init before the first load.
- With SHABAL_FEED_TIMEOUT_EN and TIMEOUT_CYC=16, ack never returned on fetch -> err=1 after 16 cycles, fetch=0, FSM in IDLE.

Source files
------------

// File: rtl/shabal_msg_feeder.sv
// shabal_msg_feeder: byte-granular message sequencer in front of SHABAL_TOP.
// Takes a 32-bit little-endian word stream, applies Shabal padding (0x80 then
// zero fill to a 16-word block), loads each word as two 16-bit halves, then
// fetches the digest and emits it as DIGEST_WORDS 32-bit words.
// Optional ack watchdog: define SHABAL_FEED_TIMEOUT_EN.
//
// Handshakes: s_* and m_* are valid/ready streams; a beat transfers on a
// rising clk edge where valid and ready are both high, and a producer holds
// valid and data stable until that edge. init/load/fetch are level requests
// held until ack is sampled high, followed by at least one idle cycle.
module shabal_msg_feeder #(
   parameter int DIGEST_WORDS = 8
`ifdef SHABAL_FEED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC  = 1024
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   input  logic        s_last,
   input  logic [1:0]  s_bytes,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_last,
   output logic        init,
   output logic        load,
   output logic        fetch,
   output logic [15:0] idata,
   input  logic        ack,
   input  logic [15:0] odata,
   output logic        err,
   output logic [3:0]  state_o
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_INIT     = 4'd1,
      S_RTZ      = 4'd2,
      S_GET      = 4'd3,
      S_LOAD_HI  = 4'd4,
      S_LOAD_LO  = 4'd5,
      S_FETCH_HI = 4'd6,
      S_FETCH_LO = 4'd7,
      S_OUT      = 4'd8
   } state_t;

   // DATA: words come from the stream; PAD: next word is 0x00000080;
   // FILL: pad already placed, remaining words of the block are zero.
   typedef enum logic [1:0] {
      PH_DATA = 2'd0,
      PH_PAD  = 2'd1,
      PH_FILL = 2'd2
   } phase_t;

   localparam int DW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;

   state_t         state_q, state_d;
   state_t         ret_q, ret_d;      // where RTZ goes next
   phase_t         phase_q, phase_d;
   logic [3:0]     wcnt_q, wcnt_d;    // word index inside the 16-word block
   logic [DW-1:0]  dcnt_q, dcnt_d;    // digest word index
   logic [31:0]    word_q, word_d;    // word currently being loaded
   logic [31:0]    mdat_q, mdat_d;    // digest word being assembled/presented
   logic           req;

   // Final partial word: keep bytes 0..n-1, put 0x80 at byte n, zero the rest.
   function automatic logic [31:0] pad_last(input logic [31:0] d, input logic [1:0] n);
      case (n)
         2'd1:    pad_last = {16'h0000, 8'h80, d[7:0]};
         2'd2:    pad_last = {8'h00, 8'h80, d[15:0]};
         2'd3:    pad_last = {8'h80, d[23:0]};
         default: pad_last = d;
      endcase
   endfunction

   assign req     = init | load | fetch;
   assign m_data  = mdat_q;
   assign state_o = state_q;

`ifdef SHABAL_FEED_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYC + 1);
   logic [WDW-1:0] wd_q;
   logic           err_q;
   logic           timeout;

   assign timeout = req && !ack && (wd_q == WDW'(TIMEOUT_CYC - 1));
   assign err     = err_q;

   // Watchdog: counts cycles a request waits for ack; sticky err on expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= (req && !ack && !timeout) ? wd_q + WDW'(1) : '0;
         err_q <= err_q | timeout;
      end
   end
`else
   assign err = 1'b0;
`endif

   // Next-state and request/stream outputs, all decoded from the current state.
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      phase_d = phase_q;
      wcnt_d  = wcnt_q;
      dcnt_d  = dcnt_q;
      word_d  = word_q;
      mdat_d  = mdat_q;
      s_ready = 1'b0;
      init    = 1'b0;
      load    = 1'b0;
      fetch   = 1'b0;
      idata   = 16'h0000;
      m_valid = 1'b0;
      m_last  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (s_valid) begin
               state_d = S_INIT;
               phase_d = PH_DATA;
               wcnt_d  = 4'd0;
               dcnt_d  = '0;
            end
         end
         S_INIT: begin
            init = 1'b1;
            if (ack) begin
               state_d = S_RTZ;
               ret_d   = S_GET;
            end
         end
         S_RTZ: state_d = ret_q;
         S_GET: begin
            case (phase_q)
               PH_DATA: begin
                  s_ready = 1'b1;
                  if (s_valid) begin
                     state_d = S_LOAD_HI;
                     word_d  = s_data;
                     if (s_last) begin
                        if (s_bytes == 2'd0) begin
                           phase_d = PH_PAD;
                        end else begin
                           word_d  = pad_last(s_data, s_bytes);
                           phase_d = PH_FILL;
                        end
                     end
                  end
               end
               PH_PAD: begin
                  word_d  = 32'h0000_0080;
                  phase_d = PH_FILL;
                  state_d = S_LOAD_HI;
               end
               default: begin
                  word_d  = 32'h0000_0000;
                  state_d = S_LOAD_HI;
               end
            endcase
         end
         S_LOAD_HI: begin
            load  = 1'b1;
            idata = word_q[31:16];
            if (ack) begin
               state_d = S_RTZ;
               ret_d   = S_LOAD_LO;
            end
         end
         S_LOAD_LO: begin
            load  = 1'b1;
            idata = word_q[15:0];
            if (ack) begin
               wcnt_d  = wcnt_q + 4'd1;
               state_d = S_RTZ;
               // Message is complete once the pad is in and the block wraps.
               ret_d   = (wcnt_q == 4'd15 && phase_q == PH_FILL) ? S_FETCH_HI : S_GET;
            end
         end
         S_FETCH_HI: begin
            fetch = 1'b1;
            if (ack) begin
               mdat_d[31:16] = odata;
               state_d       = S_RTZ;
               ret_d         = S_FETCH_LO;
            end
         end
         S_FETCH_LO: begin
            fetch = 1'b1;
            if (ack) begin
               mdat_d[15:0] = odata;
               state_d      = S_RTZ;
               ret_d        = S_OUT;
            end
         end
         S_OUT: begin
            m_valid = 1'b1;
            m_last  = (dcnt_q == DW'(DIGEST_WORDS - 1));
            if (m_ready) begin
               if (dcnt_q == DW'(DIGEST_WORDS - 1)) begin
                  state_d = S_IDLE;
               end else begin
                  dcnt_d  = dcnt_q + DW'(1);
                  state_d = S_FETCH_HI;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef SHABAL_FEED_TIMEOUT_EN
      if (timeout) begin
         state_d = S_IDLE;
      end
`endif
   end

   // State, counters and data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ret_q   <= S_IDLE;
         phase_q <= PH_DATA;
         wcnt_q  <= 4'd0;
         dcnt_q  <= '0;
         word_q  <= 32'h0000_0000;
         mdat_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         phase_q <= phase_d;
         wcnt_q  <= wcnt_d;
         dcnt_q  <= dcnt_d;
         word_q  <= word_d;
         mdat_q  <= mdat_d;
      end
   end

endmodule

// File: tb/tb_shabal_msg_feeder.sv
// Directed bench for shabal_msg_feeder with a behavioural SHABAL_TOP
// responder (programmable ack delay) and a digest consumer with one stall.
module tb_shabal_msg_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = 32'h0;
   logic        s_last = 1'b0;
   logic [1:0]  s_bytes = 2'd0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic        m_last;
   logic        init, load, fetch;
   logic [15:0] idata;
   logic        ack = 1'b0;
   logic [15:0] odata = 16'h0;
   logic        err;
   logic [3:0]  dbg_state;

   shabal_msg_feeder dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .init(init), .load(load), .fetch(fetch), .idata(idata), .ack(ack), .odata(odata),
      .err(err), .state_o(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   logic [31:0] beat_q[$];
   logic        last_q[$];
   logic [31:0] msg_w[16];
   int          viol_cnt = 0, init_cnt = 0, fetch_cnt = 0, fetch_idx = 0;
   int          wait_cnt = 0, req_idx = 0, dly_mode = 0, stall_word = -1, stall_cnt = 0;
   int          dly_tab[3] = '{0, 1, 7};
   logic        init_seen = 1'b0;
   logic [7:0]  tag = 8'h00;
   logic        p_init = 0, p_load = 0, p_fetch = 0, p_mvalid = 0, p_mready = 0, p_mlast = 0;
   logic [15:0] p_idata = 16'h0;
   logic [31:0] p_mdata = 32'h0;

   // Protocol monitor, SHABAL_TOP responder and digest consumer. At each
   // negedge, ack still holds the value the DUT sampled at the posedge just
   // passed, and p_* hold what was presented before that posedge.
   always @(negedge clk) begin
      if (rst) begin
         ack = 1'b0; m_ready = 1'b0; wait_cnt = 0; init_seen = 1'b0;
         p_init = 0; p_load = 0; p_fetch = 0; p_mvalid = 0; p_mready = 0;
      end else begin
         if (int'(init) + int'(load) + int'(fetch) > 1) viol_cnt++;
         if ((p_init || p_load || p_fetch) && !ack) begin
            if (init !== p_init || load !== p_load || fetch !== p_fetch) viol_cnt++;
            if (p_load && idata !== p_idata) viol_cnt++;
         end
         if ((p_init || p_load || p_fetch) && ack && (init || load || fetch)) viol_cnt++;
         if (p_init && ack) begin init_cnt++; init_seen = 1'b1; end
         if (p_load && ack) begin
            got_q.push_back(p_idata);
            if (!init_seen) viol_cnt++;
         end
         if (p_fetch && ack) fetch_cnt++;
         if (p_mvalid && p_mready) begin beat_q.push_back(p_mdata); last_q.push_back(p_mlast); end
         if (p_mvalid && !p_mready && (m_valid !== 1'b1 || m_data !== p_mdata || m_last !== p_mlast))
            viol_cnt++;
         if (m_valid && fetch) viol_cnt++;
         // responder: one-cycle ack pulse after the programmed delay
         if (ack) begin
            ack = 1'b0; wait_cnt = 0;
         end else if (init || load || fetch) begin
            if (wait_cnt >= ((dly_mode == 1) ? dly_tab[req_idx % 3] : 0)) begin
               ack = 1'b1; req_idx++;
               if (fetch) begin odata = {tag, 8'(fetch_idx)}; fetch_idx++; end
            end else begin
               wait_cnt++;
            end
         end
         // consumer: optional 5-cycle stall on one digest word
         if (m_valid && beat_q.size() == stall_word && stall_cnt < 5) begin
            m_ready = 1'b0; stall_cnt++;
         end else begin
            m_ready = 1'b1;
         end
         p_init = init; p_load = load; p_fetch = fetch; p_idata = idata;
         p_mvalid = m_valid; p_mready = m_ready; p_mdata = m_data; p_mlast = m_last;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_sb(input logic [7:0] t);
      exp_q.delete(); got_q.delete(); beat_q.delete(); last_q.delete();
      viol_cnt = 0; init_cnt = 0; fetch_cnt = 0; fetch_idx = 0;
      req_idx = 0; stall_cnt = 0; stall_word = -1; tag = t;
   endtask

   task automatic push_word(input logic [31:0] w);
      exp_q.push_back(w[31:16]);
      exp_q.push_back(w[15:0]);
   endtask

   // Streams msg_w[0..n-1]; abort_at>0 stops once that many halves are loaded.
   task automatic send_msg(input int n, input logic [1:0] last_bytes, input int abort_at);
      for (int i = 0; i < n; i++) begin
         int b = 0;
         s_valid = 1'b1;
         s_data  = msg_w[i];
         s_last  = (i == n - 1);
         s_bytes = (i == n - 1) ? last_bytes : 2'(i + 1);
         while (s_ready !== 1'b1) begin
            @(negedge clk);
            b++;
            if (abort_at > 0 && got_q.size() >= abort_at) begin
               s_valid = 1'b0; s_last = 1'b0;
               return;
            end
            if (b > 2000) begin
               vec_cnt++; err_cnt++;
               $display("FAIL s_ready_wait: word %0d got no s_ready, expected within 2000 cycles", i);
               s_valid = 1'b0; s_last = 1'b0;
               return;
            end
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_digest();
      int b = 0;
      while (beat_q.size() < 8 && b < 8000) begin
         @(negedge clk);
         b++;
      end
      vec_cnt++;
      if (beat_q.size() < 8) begin
         err_cnt++;
         $display("FAIL digest_timeout: got %0d beats, expected 8", beat_q.size());
      end
      repeat (2) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      vec_cnt++;
      if ({init, load, fetch, s_ready, m_valid, m_last, err} !== 7'b0) begin
         err_cnt++;
         $display("FAIL reset_ctrl: got %b expected 0000000", {init, load, fetch, s_ready, m_valid, m_last, err});
      end
      vec_cnt++;
      if ({idata, m_data} !== 48'h0) begin
         err_cnt++;
         $display("FAIL reset_data: got idata %h m_data %h expected 0", idata, m_data);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      vec_cnt++;
      if (dbg_state !== 4'd0 || {init, load, fetch, s_ready, m_valid} !== 5'b0) begin
         err_cnt++;
         $display("FAIL post_reset_idle: got state %0d ctrl %b expected 0 00000", dbg_state, {init, load, fetch, s_ready, m_valid});
      end
   endtask

   task automatic test_single_word();
      logic [31:0] dw;
      clear_sb(8'h11); dly_mode = 0;
      msg_w[0] = 32'h0063_6261;
      push_word(32'h8063_6261);
      for (int i = 1; i < 16; i++) push_word(32'h0);
      send_msg(1, 2'd3, 0);
      wait_digest();
      vec_cnt++;
      if (got_q.size() !== 32) begin err_cnt++; $display("FAIL sw_load_count: got %0d expected 32", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         vec_cnt++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL sw_load[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
         end
      end
      vec_cnt++;
      if (init_cnt !== 1 || fetch_cnt !== 16) begin
         err_cnt++; $display("FAIL sw_counts: got init %0d fetch %0d expected 1 16", init_cnt, fetch_cnt);
      end
      for (int k = 0; k < beat_q.size(); k++) begin
         dw = {tag, 8'(2 * k), tag, 8'(2 * k + 1)};
         vec_cnt++;
         if (beat_q[k] !== dw || last_q[k] !== (k == 7)) begin
            err_cnt++; $display("FAIL sw_digest[%0d]: got %h last %b expected %h last %b", k, beat_q[k], last_q[k], dw, (k == 7));
         end
      end
      vec_cnt++;
      if (viol_cnt !== 0 || dbg_state !== 4'd0) begin
         err_cnt++; $display("FAIL sw_protocol: got viol %0d state %0d expected 0 0", viol_cnt, dbg_state);
      end
   endtask

   task automatic test_two_blocks();
      clear_sb(8'h22); dly_mode = 0;
      for (int i = 0; i < 16; i++) begin
         msg_w[i] = {8'hA5, 8'(i), 8'h5A, 8'(15 - i)};
         push_word(msg_w[i]);
      end
      push_word(32'h0000_0080);
      for (int i = 1; i < 16; i++) push_word(32'h0);
      send_msg(16, 2'd0, 0);
      wait_digest();
      vec_cnt++;
      if (got_q.size() !== 64 || fetch_cnt !== 16) begin
         err_cnt++; $display("FAIL tb_counts: got loads %0d fetch %0d expected 64 16", got_q.size(), fetch_cnt);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vec_cnt++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL tb_load[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
         end
      end
      vec_cnt++;
      if (viol_cnt !== 0 || init_cnt !== 1) begin
         err_cnt++; $display("FAIL tb_protocol: got viol %0d init %0d expected 0 1", viol_cnt, init_cnt);
      end
   endtask

   task automatic test_pad_at_15();
      clear_sb(8'h33); dly_mode = 0;
      for (int i = 0; i < 15; i++) begin
         msg_w[i] = {8'hC3, 8'(i), 16'h1234};
         push_word(msg_w[i]);
      end
      push_word(32'h0000_0080);
      send_msg(15, 2'd0, 0);
      wait_digest();
      vec_cnt++;
      if (got_q.size() !== 32 || fetch_cnt !== 16) begin
         err_cnt++; $display("FAIL p15_counts: got loads %0d fetch %0d expected 32 16", got_q.size(), fetch_cnt);
      end
      for (int i = 26; i < exp_q.size(); i++) begin
         vec_cnt++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL p15_load[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
         end
      end
      vec_cnt++;
      if (beat_q.size() > 7 && beat_q[7] !== {tag, 8'd14, tag, 8'd15}) begin
         err_cnt++; $display("FAIL p15_digest7: got %h expected %h", beat_q[7], {tag, 8'd14, tag, 8'd15});
      end
   endtask

   task automatic test_ack_delays();
      clear_sb(8'h44); dly_mode = 1;
      msg_w[0] = 32'h0123_4567;
      msg_w[1] = 32'h89AB_CDEF;
      push_word(32'h0123_4567);
      push_word(32'h0000_80EF);
      for (int i = 2; i < 16; i++) push_word(32'h0);
      send_msg(2, 2'd1, 0);
      wait_digest();
      dly_mode = 0;
      for (int i = 0; i < 4; i++) begin
         vec_cnt++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL ad_load[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
         end
      end
      vec_cnt++;
      if (got_q.size() !== 32 || fetch_cnt !== 16 || init_cnt !== 1) begin
         err_cnt++; $display("FAIL ad_counts: got loads %0d fetch %0d init %0d expected 32 16 1", got_q.size(), fetch_cnt, init_cnt);
      end
      vec_cnt++;
      if (viol_cnt !== 0) begin err_cnt++; $display("FAIL ad_protocol: got %0d violations expected 0", viol_cnt); end
      vec_cnt++;
      if (beat_q.size() > 4 && beat_q[4] !== {tag, 8'd8, tag, 8'd9}) begin
         err_cnt++; $display("FAIL ad_digest4: got %h expected %h", beat_q[4], {tag, 8'd8, tag, 8'd9});
      end
   endtask

   task automatic test_out_stall();
      logic [31:0] dw;
      clear_sb(8'h55); dly_mode = 0;
      stall_word = 3;
      msg_w[0] = 32'hDEAD_BEEF;
      send_msg(1, 2'd2, 0);
      wait_digest();
      vec_cnt++;
      if (got_q.size() < 2 || {got_q[0], got_q[1]} !== 32'h0080_BEEF) begin
         err_cnt++; $display("FAIL os_padword: got %0d halves expected word 0080beef", got_q.size());
      end
      vec_cnt++;
      if (stall_cnt !== 5 || viol_cnt !== 0) begin
         err_cnt++; $display("FAIL os_stall: got stall %0d viol %0d expected 5 0", stall_cnt, viol_cnt);
      end
      for (int k = 2; k < beat_q.size() && k < 5; k++) begin
         dw = {tag, 8'(2 * k), tag, 8'(2 * k + 1)};
         vec_cnt++;
         if (beat_q[k] !== dw) begin err_cnt++; $display("FAIL os_digest[%0d]: got %h expected %h", k, beat_q[k], dw); end
      end
      vec_cnt++;
      if (last_q.size() != 8 || last_q[3] !== 1'b0 || last_q[7] !== 1'b1) begin
         err_cnt++; $display("FAIL os_last: got %0d beats expected last only on beat 7", last_q.size());
      end
   endtask

   task automatic test_reset_mid();
      clear_sb(8'h66); dly_mode = 0;
      for (int i = 0; i < 12; i++) msg_w[i] = {16'hBEE0, 8'(i), 8'h01};
      send_msg(12, 2'd0, 19);
      vec_cnt++;
      if (got_q.size() !== 19) begin err_cnt++; $display("FAIL rm_abort_point: got %0d halves expected 19", got_q.size()); end
      rst = 1'b1;
      #1;
      vec_cnt++;
      if ({init, load, fetch, s_ready, m_valid, m_last, err} !== 7'b0 || idata !== 16'h0 || dbg_state !== 4'd0) begin
         err_cnt++; $display("FAIL rm_async_reset: got ctrl %b idata %h state %0d expected 0 0 0",
                             {init, load, fetch, s_ready, m_valid, m_last, err}, idata, dbg_state);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      clear_sb(8'h77);
      msg_w[0] = 32'h0000_0061;
      push_word(32'h0000_8061);
      for (int i = 1; i < 16; i++) push_word(32'h0);
      send_msg(1, 2'd1, 0);
      wait_digest();
      vec_cnt++;
      if (init_cnt !== 1 || viol_cnt !== 0) begin
         err_cnt++; $display("FAIL rm_fresh_init: got init %0d viol %0d expected 1 0", init_cnt, viol_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         vec_cnt++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            err_cnt++; $display("FAIL rm_load[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
         end
      end
      vec_cnt++;
      if (beat_q.size() > 0 && beat_q[0] !== {tag, 8'd0, tag, 8'd1}) begin
         err_cnt++; $display("FAIL rm_digest0: got %h expected %h", beat_q[0], {tag, 8'd0, tag, 8'd1});
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      test_single_word();
      test_two_blocks();
      test_pad_at_15();
      test_ack_delays();
      test_out_stall();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
